// File: rtl/count_seq_monitor_pkg.sv
// Shared definitions for the counter sequence monitor:
// FSM state encodings and the width of the internal lock streak counter.
package count_seq_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } mon_state_e;

    // The streak counter is 4 bits wide, so LOCK_CNT can be at most 15.
    localparam int STREAK_W = 4;

endpackage : count_seq_monitor_pkg

// File: rtl/count_seq_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
// Asynchronous active-high reset.
module count_seq_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    // Count up on each request, holding once every bit is set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule : count_seq_sat_counter

// File: rtl/count_seq_monitor.sv
// Counter sequence monitor: checks that each valid sample is the previous
// accepted sample plus one (mod 2^WIDTH). It reports lock status, a wrap
// pulse, a mismatch pulse and a saturating mismatch count. All outputs are
// registered.
// Optional build macro COUNT_SEQ_MONITOR_HOLD_EN: while locked, a sample equal
// to the previous one is treated as a counter pause rather than as an error.
module count_seq_monitor
    import count_seq_monitor_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 valid_in,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 wrap_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     last_count
);

    localparam logic [STREAK_W-1:0] LOCK_TGT = STREAK_W'(LOCK_CNT);

    mon_state_e          state_q,  state_d;
    logic [WIDTH-1:0]    last_q,   last_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                locked_q, locked_d;
    logic                err_q,    err_d;
    logic                wrap_q,   wrap_d;

    logic [WIDTH-1:0]    expected;
    logic                match;
    logic                repeat_hold;

    assign expected = last_q + WIDTH'(1);
    assign match    = (count_in == expected);

`ifdef COUNT_SEQ_MONITOR_HOLD_EN
    assign repeat_hold = (count_in == last_q);
`else
    assign repeat_hold = 1'b0;
`endif

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= '0;
            streak_q <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            streak_q <= streak_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
        end
    end

    // Next-state decode: only valid samples move the FSM; pulses default low.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        streak_d = streak_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        wrap_d   = 1'b0;

        if (valid_in) begin
            unique case (state_q)
                IDLE: begin
                    last_d   = count_in;
                    streak_d = '0;
                    state_d  = ACQUIRE;
                end
                ACQUIRE: begin
                    last_d = count_in;
                    if (match) begin
                        if ((streak_q + STREAK_W'(1)) == LOCK_TGT) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end else begin
                        streak_d = '0;
                    end
                end
                LOCKED: begin
                    if (repeat_hold) begin
                        // Counter paused: nothing changes.
                        state_d = LOCKED;
                    end else if (match) begin
                        last_d = count_in;
                        wrap_d = (last_q == '1);
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        streak_d = '0;
                        last_d   = count_in;
                        state_d  = ACQUIRE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    streak_d = '0;
                end
            endcase
        end
    end

    // Mismatch counter advances on the same edge that raises err_pulse.
    count_seq_sat_counter #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .inc_i   (err_d),
        .count_o (err_count)
    );

    assign locked     = locked_q;
    assign err_pulse  = err_q;
    assign wrap_pulse = wrap_q;
    assign last_count = last_q;

endmodule : count_seq_monitor

// File: tb/tb_count_seq_monitor.sv
// Self-checking bench for count_seq_monitor. Two instances share stimulus:
// one with an 8-bit error counter and one with a 2-bit error counter so the
// saturation behaviour can be observed.
module tb_count_seq_monitor;

    localparam int WIDTH    = 3;
    localparam int LOCK_CNT = 2;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] count_in;
    logic             valid_in;

    logic             locked,  err_pulse,  wrap_pulse;
    logic [7:0]       err_count;
    logic [WIDTH-1:0] last_count;

    logic             locked2, err_pulse2, wrap_pulse2;
    logic [1:0]       err_count2;
    logic [WIDTH-1:0] last_count2;

    count_seq_monitor #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .valid_in   (valid_in),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count),
        .last_count (last_count)
    );

    count_seq_monitor #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .valid_in   (valid_in),
        .locked     (locked2),
        .err_pulse  (err_pulse2),
        .wrap_pulse (wrap_pulse2),
        .err_count  (err_count2),
        .last_count (last_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             lk;
        logic             er;
        logic             wr;
        logic [7:0]       ec;
        logic [1:0]       ec2;
        logic [WIDTH-1:0] last;
    } exp_t;

    exp_t sb[$];

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "init";

    // Reference model state
    int               m_state;
    logic [WIDTH-1:0] m_last;
    int               m_streak;
    logic             m_locked;
    int               m_ec8;
    int               m_ec2;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %0d, expected %0d", phase, tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_last   = '0;
        m_streak = 0;
        m_locked = 1'b0;
        m_ec8    = 0;
        m_ec2    = 0;
    endtask

    task automatic model_step(input logic v, input logic [WIDTH-1:0] c, output exp_t e);
        logic er;
        logic wr;
        logic [WIDTH-1:0] nxt;
        er  = 1'b0;
        wr  = 1'b0;
        nxt = m_last + WIDTH'(1);
        if (v) begin
            if (m_state == 0) begin
                m_last   = c;
                m_streak = 0;
                m_state  = 1;
            end else if (m_state == 1) begin
                if (c == nxt) begin
                    if (m_streak + 1 == LOCK_CNT) begin
                        m_state  = 2;
                        m_locked = 1'b1;
                    end else begin
                        m_streak = m_streak + 1;
                    end
                end else begin
                    m_streak = 0;
                end
                m_last = c;
            end else begin
`ifdef COUNT_SEQ_MONITOR_HOLD_EN
                if (c == m_last) begin
                    // pause: no change
                end else
`endif
                if (c == nxt) begin
                    wr     = (m_last == {WIDTH{1'b1}});
                    m_last = c;
                end else begin
                    er       = 1'b1;
                    m_locked = 1'b0;
                    m_streak = 0;
                    m_last   = c;
                    m_state  = 1;
                    if (m_ec8 != 255) m_ec8 = m_ec8 + 1;
                    if (m_ec2 != 3)   m_ec2 = m_ec2 + 1;
                end
            end
        end
        e.lk   = m_locked;
        e.er   = er;
        e.wr   = wr;
        e.ec   = 8'(m_ec8);
        e.ec2  = 2'(m_ec2);
        e.last = m_last;
    endtask

    // Drive one sample, let one edge pass, then compare both instances.
    task automatic step(input logic v, input logic [WIDTH-1:0] c);
        exp_t e;
        valid_in = v;
        count_in = c;
        model_step(v, c, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("locked",     int'(locked),      int'(e.lk));
        check_eq("err_pulse",  int'(err_pulse),   int'(e.er));
        check_eq("wrap_pulse", int'(wrap_pulse),  int'(e.wr));
        check_eq("err_count",  int'(err_count),   int'(e.ec));
        check_eq("last_count", int'(last_count),  int'(e.last));
        check_eq("locked2",    int'(locked2),     int'(e.lk));
        check_eq("err_pulse2", int'(err_pulse2),  int'(e.er));
        check_eq("wrap2",      int'(wrap_pulse2), int'(e.wr));
        check_eq("err_count2", int'(err_count2),  int'(e.ec2));
        check_eq("last2",      int'(last_count2), int'(e.last));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".locked"},     int'(locked),      0);
        check_eq({tag, ".err_pulse"},  int'(err_pulse),   0);
        check_eq({tag, ".wrap_pulse"}, int'(wrap_pulse),  0);
        check_eq({tag, ".err_count"},  int'(err_count),   0);
        check_eq({tag, ".last_count"}, int'(last_count),  0);
        check_eq({tag, ".err_count2"}, int'(err_count2),  0);
        check_eq({tag, ".locked2"},    int'(locked2),     0);
        check_eq({tag, ".last2"},      int'(last_count2), 0);
    endtask

    // Assert reset between clock edges, check it took effect before the next
    // edge, then release it away from an edge.
    task automatic async_reset(input string tag);
        reset    = 1'b1;
        valid_in = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [WIDTH-1:0] cur;
        int exp_ec2 [5] = '{1, 2, 3, 3, 3};

        reset    = 1'b1;
        valid_in = 1'b0;
        count_in = '0;
        model_reset();
        #3;
        phase = "reset";
        check_all_zero("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Test 1: lock on 0,1,2
        phase = "t1_lock";
        step(1'b1, 3'd0);
        step(1'b1, 3'd1);
        check_eq("not_yet_locked", int'(locked), 0);
        step(1'b1, 3'd2);
        check_eq("locked_after_2", int'(locked), 1);

        // Test 2: wrap 7 -> 0 while locked
        phase = "t2_wrap";
        step(1'b1, 3'd3);
        step(1'b1, 3'd4);
        step(1'b1, 3'd5);
        step(1'b1, 3'd6);
        step(1'b1, 3'd7);
        step(1'b1, 3'd0);
        check_eq("wrap_seen", int'(wrap_pulse), 1);
        step(1'b1, 3'd1);
        check_eq("wrap_one_cycle", int'(wrap_pulse), 0);

        // Test 3: locked at 3, jump to 5, then relock on 6,7
        phase = "t3_err";
        step(1'b1, 3'd2);
        step(1'b1, 3'd3);
        step(1'b1, 3'd5);
        check_eq("err_seen", int'(err_pulse), 1);
        check_eq("err_cnt1", int'(err_count), 1);
        step(1'b1, 3'd6);
        step(1'b1, 3'd7);
        check_eq("relocked", int'(locked), 1);

        // Test 4: valid low holds everything
        phase = "t4_hold_valid";
        step(1'b1, 3'd0);
        step(1'b1, 3'd1);
        step(1'b0, 3'd4);
        step(1'b0, 3'd4);
        step(1'b0, 3'd4);
        step(1'b1, 3'd2);
        check_eq("still_locked", int'(locked), 1);
        check_eq("last_is_2", int'(last_count), 2);

        // Test 6: async reset while locked with err_count=2
        phase = "t6_async";
        async_reset("pre6");
        step(1'b1, 3'd0);
        step(1'b1, 3'd1);
        step(1'b1, 3'd2);
        step(1'b1, 3'd5);
        step(1'b1, 3'd6);
        step(1'b1, 3'd7);
        step(1'b1, 3'd2);
        step(1'b1, 3'd3);
        step(1'b1, 3'd4);
        check_eq("ec_before_rst", int'(err_count), 2);
        check_eq("lk_before_rst", int'(locked), 1);
        async_reset("mid");

        // Test 5: saturation of the 2-bit counter across five errors
        phase = "t5_sat";
        step(1'b1, 3'd0);
        step(1'b1, 3'd1);
        step(1'b1, 3'd2);
        cur = 3'd2;
        for (int i = 0; i < 5; i++) begin
            cur = cur + 3'd3;
            step(1'b1, cur);
            check_eq("sat_pulse", int'(err_pulse2), 1);
            check_eq("sat_count", int'(err_count2), exp_ec2[i]);
            cur = cur + 3'd1;
            step(1'b1, cur);
            cur = cur + 3'd1;
            step(1'b1, cur);
            check_eq("sat_relock", int'(locked2), 1);
        end
        check_eq("ec8_five", int'(err_count), 5);

`ifdef COUNT_SEQ_MONITOR_HOLD_EN
        // Repeat while locked is a pause
        phase = "hold_feature";
        async_reset("pre_hold");
        step(1'b1, 3'd2);
        step(1'b1, 3'd3);
        step(1'b1, 3'd4);
        step(1'b1, 3'd4);
        check_eq("pause_no_err", int'(err_pulse), 0);
        check_eq("pause_locked", int'(locked), 1);
        step(1'b1, 3'd5);
`else
        // Repeat while locked is a mismatch
        phase = "repeat_err";
        step(1'b1, cur);
        check_eq("repeat_err", int'(err_pulse), 1);
`endif

        valid_in = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_count_seq_monitor
